// File: rtl/uart_rx_ctl_fifo.sv
// UART RX controller: captures received words into a show-ahead FIFO, throttles the
// receiver near full. Define UART_RX_CTL_OVR_EN to build the sticky overrun flag.
module uart_rx_ctl_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     RX_Done_Sig,
   input  logic [DATA_W-1:0]        RX_Data,
   output logic                     RX_En_Sig,
   output logic [DATA_W-1:0]        Num_Data,
   output logic                     Data_Valid,
   input  logic                     Rd_Ack,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Ovr_Flag,
   input  logic                     Ovr_Clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t              state;
   state_t              next_state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [CW-1:0]       next_count;
   logic                full;
   logic                pop;
   logic                push;
   logic                overrun;
   logic                en_next;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign full       = (count == FULL_CNT);
   assign pop        = Rd_Ack && (count != '0);
   assign push       = RX_Done_Sig && (!full || pop);
   assign overrun    = RX_Done_Sig && full && !pop;
   assign next_count = count + CW'(push) - CW'(pop);

   assign Count      = count;
   assign Data_Valid = (count != '0);
   assign Num_Data   = Data_Valid ? mem[rd_ptr] : '0;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= RX_Data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= next_count;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         RX_En_Sig <= 1'b0;
      end else begin
         state     <= next_state;
         RX_En_Sig <= en_next;
      end
   end

   // Enable follows the state entered on this edge; leaving IDLE costs one extra cycle.
   always_comb begin
      next_state = state;
      en_next    = 1'b0;
      case (state)
         IDLE:    next_state = RUN;
         RUN:     if (next_count >= AFULL_CNT) next_state = HOLD;
         HOLD:    if (next_count < AFULL_CNT) next_state = RUN;
         default: next_state = IDLE;
      endcase
      en_next = (state != IDLE) && (next_state == RUN) && !RX_Done_Sig;
   end

`ifdef UART_RX_CTL_OVR_EN
   // A new overrun wins over a clear in the same cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)        Ovr_Flag <= 1'b0;
      else if (overrun) Ovr_Flag <= 1'b1;
      else if (Ovr_Clr) Ovr_Flag <= 1'b0;
   end
`else
   logic unused_ovr;
   assign unused_ovr = Ovr_Clr ^ overrun;
   assign Ovr_Flag   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctl_fifo.sv
// Directed self-checking bench for uart_rx_ctl_fifo (DEPTH=16, AFULL_LVL=14).
module tb_uart_rx_ctl_fifo;

   logic       CLK;
   logic       RSTn;
   logic       RX_Done_Sig;
   logic [7:0] RX_Data;
   logic       RX_En_Sig;
   logic [7:0] Num_Data;
   logic       Data_Valid;
   logic       Rd_Ack;
   logic [4:0] Count;
   logic       Ovr_Flag;
   logic       Ovr_Clr;

   int vectors = 0;
   int errors  = 0;

`ifdef UART_RX_CTL_OVR_EN
   localparam logic OVR_ON = 1'b1;
`else
   localparam logic OVR_ON = 1'b0;
`endif

   uart_rx_ctl_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(14)) dut (
      .CLK(CLK), .RSTn(RSTn), .RX_Done_Sig(RX_Done_Sig), .RX_Data(RX_Data),
      .RX_En_Sig(RX_En_Sig), .Num_Data(Num_Data), .Data_Valid(Data_Valid),
      .Rd_Ack(Rd_Ack), .Count(Count), .Ovr_Flag(Ovr_Flag), .Ovr_Clr(Ovr_Clr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [7:0] word);
      RX_Done_Sig = 1'b1;
      RX_Data     = word;
      tick();
      RX_Done_Sig = 1'b0;
   endtask

   task automatic pop();
      Rd_Ack = 1'b1;
      tick();
      Rd_Ack = 1'b0;
   endtask

   task automatic test_reset();
      RSTn = 1'b0; RX_Done_Sig = 1'b0; RX_Data = '0; Rd_Ack = 1'b0; Ovr_Clr = 1'b0;
      tick(); tick();
      vectors++;
      if ({RX_En_Sig, Data_Valid, Num_Data, Count, Ovr_Flag} !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got en=%b dv=%b num=%h cnt=%0d ovr=%b, want all 0",
                  RX_En_Sig, Data_Valid, Num_Data, Count, Ovr_Flag);
      end
      RSTn = 1'b1;
      tick();
      vectors++;
      if (RX_En_Sig !== 1'b0) begin
         errors++; $display("[TB] FAIL en_first_edge: got %b want 0", RX_En_Sig);
      end
      tick();
      vectors++;
      if (RX_En_Sig !== 1'b1) begin
         errors++; $display("[TB] FAIL en_second_edge: got %b want 1", RX_En_Sig);
      end
   endtask

   task automatic test_single();
      push(8'hA5);
      vectors++;
      if ({Data_Valid, Num_Data, Count, RX_En_Sig} !== {1'b1, 8'hA5, 5'd1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL single_push: got dv=%b num=%h cnt=%0d en=%b want 1 a5 1 0",
                  Data_Valid, Num_Data, Count, RX_En_Sig);
      end
      tick();
      vectors++;
      if (RX_En_Sig !== 1'b1) begin
         errors++; $display("[TB] FAIL rearm_gap: got en=%b want 1", RX_En_Sig);
      end
      pop();
      vectors++;
      if ({Data_Valid, Num_Data, Count} !== 14'h0) begin
         errors++;
         $display("[TB] FAIL single_pop: got dv=%b num=%h cnt=%0d want 0 00 0",
                  Data_Valid, Num_Data, Count);
      end
   endtask

   task automatic test_afull();
      for (int i = 0; i < 14; i++) begin
         push(8'(i));
         tick();
         vectors++;
         if (RX_En_Sig !== ((i + 1) < 14) || Count !== 5'(i + 1)) begin
            errors++;
            $display("[TB] FAIL afull_fill[%0d]: got en=%b cnt=%0d want en=%b cnt=%0d",
                     i, RX_En_Sig, Count, ((i + 1) < 14), i + 1);
         end
      end
      pop();
      vectors++;
      if (RX_En_Sig !== 1'b1 || Count !== 5'd13) begin
         errors++;
         $display("[TB] FAIL afull_release: got en=%b cnt=%0d want 1 13", RX_En_Sig, Count);
      end
      for (int i = 1; i < 14; i++) begin
         vectors++;
         if (Num_Data !== 8'(i)) begin
            errors++; $display("[TB] FAIL afull_drain[%0d]: got %h want %h", i, Num_Data, 8'(i));
         end
         pop();
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) push(8'(i));
      vectors++;
      if (Count !== 5'd16 || Ovr_Flag !== 1'b0) begin
         errors++; $display("[TB] FAIL fill16: got cnt=%0d ovr=%b want 16 0", Count, Ovr_Flag);
      end
      push(8'hEE);
      vectors++;
      if (Count !== 5'd16 || Ovr_Flag !== OVR_ON || Num_Data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL overrun: got cnt=%0d ovr=%b head=%h want 16 %b 00",
                  Count, Ovr_Flag, Num_Data, OVR_ON);
      end
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (Num_Data !== 8'(i) || Data_Valid !== 1'b1) begin
            errors++; $display("[TB] FAIL overrun_drain[%0d]: got %h want %h", i, Num_Data, 8'(i));
         end
         pop();
      end
      vectors++;
      if (Data_Valid !== 1'b0 || Num_Data !== 8'h00) begin
         errors++; $display("[TB] FAIL overrun_empty: got dv=%b num=%h want 0 00", Data_Valid, Num_Data);
      end
      Ovr_Clr = 1'b1; tick(); Ovr_Clr = 1'b0;
      vectors++;
      if (Ovr_Flag !== 1'b0) begin
         errors++; $display("[TB] FAIL ovr_clear: got %b want 0", Ovr_Flag);
      end
   endtask

   task automatic test_full_concurrent();
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      RX_Done_Sig = 1'b1; RX_Data = 8'h77; Rd_Ack = 1'b1;
      tick();
      RX_Done_Sig = 1'b0; Rd_Ack = 1'b0;
      vectors++;
      if (Count !== 5'd16 || Ovr_Flag !== 1'b0 || Num_Data !== 8'h11) begin
         errors++;
         $display("[TB] FAIL full_push_pop: got cnt=%0d ovr=%b head=%h want 16 0 11",
                  Count, Ovr_Flag, Num_Data);
      end
      for (int i = 1; i < 17; i++) begin
         vectors++;
         if (Num_Data !== ((i == 16) ? 8'h77 : 8'h10 + 8'(i))) begin
            errors++;
            $display("[TB] FAIL wrap_drain[%0d]: got %h want %h", i, Num_Data,
                     ((i == 16) ? 8'h77 : 8'h10 + 8'(i)));
         end
         pop();
      end
   endtask

   task automatic test_back_to_back();
      RX_Done_Sig = 1'b1; RX_Data = 8'h3C; Rd_Ack = 1'b1;
      tick();
      RX_Done_Sig = 1'b0; Rd_Ack = 1'b0;
      vectors++;
      if (Count !== 5'd1 || Num_Data !== 8'h3C || Data_Valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL empty_push_pop: got cnt=%0d num=%h dv=%b want 1 3c 1",
                  Count, Num_Data, Data_Valid);
      end
      for (int i = 0; i < 15; i++) push(8'h40 + 8'(i));
      RX_Done_Sig = 1'b1; RX_Data = 8'h99; Ovr_Clr = 1'b1;
      tick();
      RX_Done_Sig = 1'b0; Ovr_Clr = 1'b0;
      vectors++;
      if (Ovr_Flag !== OVR_ON || Count !== 5'd16) begin
         errors++;
         $display("[TB] FAIL clr_vs_overrun: got ovr=%b cnt=%0d want %b 16", Ovr_Flag, Count, OVR_ON);
      end
      Ovr_Clr = 1'b1; tick(); Ovr_Clr = 1'b0;
      vectors++;
      if (Ovr_Flag !== 1'b0) begin
         errors++; $display("[TB] FAIL clr_alone: got %b want 0", Ovr_Flag);
      end
      push(8'h98);
      vectors++;
      if (Ovr_Flag !== OVR_ON) begin
         errors++; $display("[TB] FAIL reoverrun: got %b want %b", Ovr_Flag, OVR_ON);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 11; i++) pop();
      vectors++;
      if (Count !== 5'd5 || Ovr_Flag !== OVR_ON || Num_Data !== 8'h4A) begin
         errors++;
         $display("[TB] FAIL pre_reset: got cnt=%0d ovr=%b head=%h want 5 %b 4a",
                  Count, Ovr_Flag, Num_Data, OVR_ON);
      end
      #2 RSTn = 1'b0;
      #1;
      vectors++;
      if ({RX_En_Sig, Data_Valid, Num_Data, Count, Ovr_Flag} !== 16'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: got en=%b dv=%b num=%h cnt=%0d ovr=%b want all 0",
                  RX_En_Sig, Data_Valid, Num_Data, Count, Ovr_Flag);
      end
      tick();
      RSTn = 1'b1;
      tick(); tick();
      push(8'h5A);
      vectors++;
      if (Num_Data !== 8'h5A || Count !== 5'd1) begin
         errors++;
         $display("[TB] FAIL post_reset_push: got num=%h cnt=%0d want 5a 1", Num_Data, Count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_afull();
      test_overrun();
      test_full_concurrent();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctl_fifo.md
# uart_rx_ctl_fifo

Parametrised receive-side controller for the UART RX path. It sits between the bit-level receiver and the consumer logic. Each received word, signalled by a one-cycle `RX_Done_Sig` strobe, is captured into an internal FIFO and presented to the consumer with a valid/acknowledge handshake. The block throttles the receiver through `RX_En_Sig` when the FIFO nears full, and flags overruns.

## Interface
- `DATA_W`, default 8: received word width.
- `DEPTH`, default 16: FIFO entries; a power of two, ≥2.
- `AFULL_LVL`, default `DEPTH-2`: occupancy at or above which the receiver is held off; range 1..`DEPTH`.
- `CLK`  in  1: clock; all state changes on rising edge.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `RX_Done_Sig`  in  1: one-cycle strobe; `RX_Data` valid this cycle.
- `RX_Data`  in  `DATA_W`: received word.
- `RX_En_Sig`  out  1: receiver enable; registered.
- `Num_Data`  out  `DATA_W`: FIFO head word; 0 when `Data_Valid`=0.
- `Data_Valid`  out  1: FIFO not empty.
- `Rd_Ack`  in  1: consumer pops the head this cycle.
- `Count`  out  `$clog2(DEPTH)+1`: current occupancy.
- `Ovr_Flag`  out  1: sticky overrun indicator.
- `Ovr_Clr`  in  1: clears `Ovr_Flag`.

## Operation
- Storage: `DEPTH`×`DATA_W` register array. Write and read pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `Count` is tracked explicitly.
- Push: `RX_Done_Sig`=1 and (`Count`<`DEPTH` or pop this cycle). The word is written at the write pointer, and the pointer increments.
- Pop: `Rd_Ack`=1 and `Data_Valid`=1. The read pointer increments. `Rd_Ack` while empty is ignored.
- Simultaneous push and pop: `Count` is unchanged. When full, the push is accepted because the pop frees a slot. When empty, only the push takes effect.
- `Num_Data` = array[read pointer] when `Data_Valid`, else 0 (show-ahead).
- Overrun: `RX_Done_Sig` while `Count`=`DEPTH` and no pop. The word is dropped, and the array, pointers and `Count` are unchanged.
- Control FSM: IDLE → RUN → HOLD.
  - IDLE is the reset state; it moves to RUN on the first edge after reset release.
  - RUN → HOLD when next `Count` ≥ `AFULL_LVL`.
  - HOLD → RUN when next `Count` < `AFULL_LVL`.
- `RX_En_Sig` next-state logic:
  - 1 in RUN, except 0 for the cycle after any `RX_Done_Sig` (receiver re-arm gap).
  - 0 in IDLE and HOLD.
- Reset mid-operation clears pointers, `Count`, the array, `Ovr_Flag` and the FSM immediately. In-flight data is discarded.

## Timing
- Reset values:
  - `RX_En_Sig`=0, `Num_Data`=0, `Data_Valid`=0, `Count`=0, `Ovr_Flag`=0.
  - FSM = IDLE; array cleared to 0.
- Push latency: strobe in cycle N gives `Data_Valid`, `Num_Data` and `Count` updated after edge N+1.
- Pop: `Rd_Ack` in cycle N means the next head (or 0/`Data_Valid`=0) appears after edge N+1.
- `RX_En_Sig` after reset release: first edge gives RUN, `RX_En_Sig`=1 from the second edge.
- `RX_En_Sig` reacts to the `Count` produced by the same edge, with no extra cycle of slip.
- Throughput: one push and one pop per cycle.

## Configuration
- `UART_RX_CTL_OVR_EN` defined:
  - Overrun sets `Ovr_Flag` on the next edge; it holds until an edge with `Ovr_Clr`=1.
  - `Ovr_Clr` and a new overrun in the same cycle leave the flag set.
- Undefined:
  - `Ovr_Flag` is tied to 0, `Ovr_Clr` is ignored, and no flag register is built.
  - Overrun words are still dropped silently.

## Test plan
- Reset, then after release, single `RX_Done_Sig` with `RX_Data`=8'hA5 → `Data_Valid`=1, `Num_Data`=8'hA5, `Count`=1 one edge later. `RX_En_Sig`: 0 for one cycle, then 1. `Rd_Ack` → `Data_Valid`=0, `Num_Data`=0.
- `DEPTH`=16, `AFULL_LVL`=14, push 0x00..0x0D without popping → `RX_En_Sig` falls on the edge where `Count`=14. Pop one → `RX_En_Sig`=1 when `Count`=13.
- Fill to 16 (0x00..0x0F), one more strobe with 0xEE, no pop → `Count`=16, `Ovr_Flag`=1 (with macro). Pop all → 0x00..0x0F in order; 0xEE absent.
- Full FIFO, strobe 0x77 concurrent with `Rd_Ack` → `Count` stays 16, no overrun. 0x77 is read last after 32 pushes total, confirming pointer wrap.
- Empty FIFO, strobe plus `Rd_Ack` same cycle → `Count`=1, `Num_Data`=strobe word. `Ovr_Clr` concurrent with an overrun → `Ovr_Flag` remains 1.
- `RSTn` pulsed low with `Count`=5 and `Ovr_Flag`=1 → all outputs at reset values asynchronously. The next push reads back at the head.
